// File: rtl/fixed_point_mul_pipe.sv
// Three-stage pipelined signed fixed-point multiplier with valid/ready flow control,
// per-transaction round/saturate modes. Define FXP_MUL_OVF_CNT_EN to add the ovf_count output.
module fixed_point_mul_pipe #(
  parameter int unsigned INT_A    = 4,
  parameter int unsigned FRAC_A   = 12,
  parameter int unsigned INT_B    = 4,
  parameter int unsigned FRAC_B   = 12,
  parameter int unsigned INT_OUT  = 4,
  parameter int unsigned FRAC_OUT = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_A+FRAC_A-1:0]       a,
  input  logic [INT_B+FRAC_B-1:0]       b,
  input  logic                          round_en,
  input  logic                          sat_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_OUT+FRAC_OUT-1:0]   product,
  output logic                          overflow,
  output logic                          inexact
`ifdef FXP_MUL_OVF_CNT_EN
  ,
  output logic [15:0]                   ovf_count
`endif
);

  localparam int unsigned WA  = INT_A + FRAC_A;
  localparam int unsigned WB  = INT_B + FRAC_B;
  localparam int unsigned WO  = INT_OUT + FRAC_OUT;
  localparam int unsigned PW  = WA + WB;
  localparam int unsigned FP  = FRAC_A + FRAC_B;
  localparam int unsigned SHL = (FRAC_OUT >= FP) ? FRAC_OUT - FP : 0;
  localparam int unsigned SHR = (FRAC_OUT >= FP) ? 0 : FP - FRAC_OUT;
  // One guard bit above the aligned product keeps the rounding add from wrapping.
  localparam int unsigned EW0 = PW + SHL + 1;
  localparam int unsigned EW  = (EW0 > WO + 1) ? EW0 : WO + 1;

  logic                 w_adv;
  logic signed [WA-1:0] r_a;
  logic signed [WB-1:0] r_b;
  logic                 r_rnd1, r_sat1, r_v1;
  logic signed [PW-1:0] w_ma, w_mb;
  logic signed [PW-1:0] r_p;
  logic                 r_rnd2, r_sat2, r_v2;
  logic signed [EW-1:0] w_pext, w_r;
  logic                 w_inexact, w_ovf;
  logic [WO-1:0]        w_res;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_rnd1 <= 1'b0;
      r_sat1 <= 1'b0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_a    <= a;
      r_b    <= b;
      r_rnd1 <= round_en;
      r_sat1 <= sat_en;
    end
  end

  assign w_ma = PW'(r_a);
  assign w_mb = PW'(r_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_p    <= '0;
      r_rnd2 <= 1'b0;
      r_sat2 <= 1'b0;
    end else if (w_adv) begin
      r_v2   <= r_v1;
      r_p    <= w_ma * w_mb;
      r_rnd2 <= r_rnd1;
      r_sat2 <= r_sat1;
    end
  end

  assign w_pext = EW'(r_p);

  generate
    if (SHR == 0) begin : g_align_left
      assign w_r       = w_pext <<< SHL;
      assign w_inexact = 1'b0;
    end else begin : g_align_right
      logic signed [EW-1:0] w_half;
      assign w_half    = r_rnd2 ? (EW'(1) << (SHR - 1)) : '0;
      assign w_inexact = |r_p[SHR-1:0];
      assign w_r       = (w_pext + w_half) >>> SHR;
    end
  endgenerate

  // Fits in WO bits exactly when every bit from the result sign upward agrees.
  assign w_ovf = ~((&w_r[EW-1:WO-1]) | ~(|w_r[EW-1:WO-1]));

  always_comb begin
    w_res = w_r[WO-1:0];
    if (w_ovf && r_sat2) begin
      w_res = w_r[EW-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_v2;
      product   <= w_res;
      overflow  <= w_ovf;
      inexact   <= w_inexact;
    end
  end

`ifdef FXP_MUL_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (out_valid && out_ready && overflow && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_count = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Self-checking bench for fixed_point_mul_pipe in its default Q4.12 x Q4.12 -> Q4.12 form.
module tb_fixed_point_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        round_en;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        overflow;
  logic        inexact;
`ifdef FXP_MUL_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  fixed_point_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .round_en  (round_en),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .inexact   (inexact)
`ifdef FXP_MUL_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] p;
    logic        ovf;
    logic        inx;
  } exp_t;

  int   n_checks;
  int   n_errors;
  exp_t q[$];

  // Real-valued rule: product of two Q4.12 values, scaled back to 12 fraction bits with floor,
  // optional +half-LSB before the floor, then range-checked against a signed 16-bit result.
  function automatic exp_t model(input logic [15:0] fa, input logic [15:0] fb,
                                 input logic frnd, input logic fsat);
    longint pp;
    longint rr;
    exp_t   e;
    pp    = longint'($signed(fa)) * longint'($signed(fb));
    e.inx = (pp % 4096) != 0;
    rr    = (pp + (frnd ? 2048 : 0)) >>> 12;
    e.ovf = (rr > 32767) || (rr < -32768);
    if (e.ovf && fsat) e.p = (rr < 0) ? 16'h8000 : 16'h7FFF;
    else               e.p = rr[15:0];
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_one(input logic [15:0] ta, input logic [15:0] tb_, input logic tr,
                        input logic ts, output exp_t got, output int lat);
    @(negedge clk);
    a = ta; b = tb_; round_en = tr; sat_en = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got.p = product; got.ovf = overflow; got.inx = inexact;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (product !== 16'h0) begin n_errors++; $display("FAIL reset_product got=%h want=0000", product); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    n_checks++; if (inexact !== 1'b0) begin n_errors++; $display("FAIL reset_inexact got=%b want=0", inexact); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] va [11] = '{16'h1800, 16'h7000, 16'h7000, 16'h8000, 16'h0001, 16'h0001,
                             16'hFFFF, 16'hFFFF, 16'h7800, 16'h7800, 16'h7800};
    logic [15:0] vb [11] = '{16'h2000, 16'h2000, 16'h2000, 16'h8000, 16'h0800, 16'h0800,
                             16'h0800, 16'h0800, 16'h1111, 16'h1111, 16'h1111};
    logic        vr [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1};
    logic        vs [11] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [15:0] ep [11] = '{16'h3000, 16'h7FFF, 16'hE000, 16'h7FFF, 16'h0000, 16'h0001,
                             16'hFFFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000};
    logic        eo [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    logic        ei [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    exp_t got;
    int   lat;
    for (int i = 0; i < 11; i++) begin
      do_one(va[i], vb[i], vr[i], vs[i], got, lat);
      n_checks++;
      if (lat !== 3) begin n_errors++; $display("FAIL dir%0d_latency got=%0d want=3", i, lat); end
      n_checks++;
      if (got.p !== ep[i]) begin n_errors++; $display("FAIL dir%0d_product got=%h want=%h", i, got.p, ep[i]); end
      n_checks++;
      if (got.ovf !== eo[i]) begin n_errors++; $display("FAIL dir%0d_overflow got=%b want=%b", i, got.ovf, eo[i]); end
      n_checks++;
      if (got.inx !== ei[i]) begin n_errors++; $display("FAIL dir%0d_inexact got=%b want=%b", i, got.inx, ei[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   rcvd;
    logic held;
    exp_t prev;
    exp_t e;
    exp_t cur;
    q.delete();
    sent = 0; rcvd = 0; held = 1'b0; prev = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      a         = 16'($urandom);
      b         = 16'($urandom);
      round_en  = 1'($urandom);
      sat_en    = 1'($urandom);
      out_ready = !(c >= 4 && c <= 7);
      #4;
      cur.p = product; cur.ovf = overflow; cur.inx = inexact;
      if (c < 8) begin
        n_checks++;
        if (in_ready !== (c < 4)) begin
          n_errors++; $display("FAIL b2b_in_ready cycle=%0d got=%b want=%b", c, in_ready, c < 4);
        end
      end
      if (held) begin
        n_checks++;
        if (!out_valid || cur !== prev) begin
          n_errors++; $display("FAIL b2b_stall_hold cycle=%0d got=%h want=%h", c, cur, prev);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, round_en, sat_en));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL b2b_unexpected_result got=%h want=none", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin n_errors++; $display("FAIL b2b_result%0d got=%h want=%h", rcvd, cur, e); end
        end
        rcvd++;
      end
      held = out_valid && !out_ready;
      prev = cur;
    end
    n_checks++;
    if (rcvd !== 8) begin n_errors++; $display("FAIL b2b_count got=%0d want=8", rcvd); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_random_stream();
    int   rcvd;
    logic held;
    exp_t prev;
    exp_t e;
    exp_t cur;
    q.delete();
    rcvd = 0; held = 1'b0; prev = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c < 400) begin
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      a        = 16'($urandom);
      b        = 16'($urandom);
      round_en = 1'($urandom);
      sat_en   = 1'($urandom);
      #4;
      cur.p = product; cur.ovf = overflow; cur.inx = inexact;
      if (held) begin
        n_checks++;
        if (!out_valid || cur !== prev) begin
          n_errors++; $display("FAIL rnd_stall_hold cycle=%0d got=%h want=%h", c, cur, prev);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, round_en, sat_en));
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL rnd_unexpected_result got=%h want=none", cur);
        end else begin
          e = q.pop_front();
          if (cur !== e) begin n_errors++; $display("FAIL rnd_result%0d got=%h want=%h", rcvd, cur, e); end
        end
        rcvd++;
      end
      held = out_valid && !out_ready;
      prev = cur;
      if (c >= 400 && q.size() == 0 && !out_valid) break;
    end
    n_checks++;
    if (q.size() != 0) begin n_errors++; $display("FAIL rnd_drain left=%0d want=0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    exp_t got;
    int   lat;
    @(negedge clk);
    a = 16'h1800; b = 16'h2000; round_en = 1'b0; sat_en = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a = 16'h7000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    n_checks++; if (product !== 16'h0) begin n_errors++; $display("FAIL midrst_product got=%h want=0000", product); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_ghost%0d got=%b want=0", i, out_valid); end
    end
    do_one(16'h1800, 16'h2000, 1'b0, 1'b1, got, lat);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL midrst_latency got=%0d want=3", lat); end
    n_checks++; if (got.p !== 16'h3000) begin n_errors++; $display("FAIL midrst_product_after got=%h want=3000", got.p); end
  endtask

`ifdef FXP_MUL_OVF_CNT_EN
  task automatic test_ovf_count();
    exp_t got;
    int   lat;
    apply_reset();
    for (int i = 0; i < 3; i++) do_one(16'h7000, 16'h2000, 1'b0, 1'b1, got, lat);
    for (int i = 0; i < 2; i++) do_one(16'h1800, 16'h2000, 1'b0, 1'b1, got, lat);
    n_checks++;
    if (ovf_count !== 16'd3) begin n_errors++; $display("FAIL ovf_count got=%0d want=3", ovf_count); end
  endtask
`endif

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; round_en = 1'b0; sat_en = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_stream();
    test_reset_midflight();
`ifdef FXP_MUL_OVF_CNT_EN
    test_ovf_count();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
